ram_1r1w_arb: RTL and testbench
===============================

# ram_1R1W_arb

Shares one 1R1W RAM port pair between N_RD read requesters and N_WR write requesters. Each side uses independent round-robin arbitration, with a registered command stage toward the RAM and in-order read-response tagging. It also blocks same-cycle read/write address collisions so every read returns post-write data. It sits in front of a 1R1W behavioural RAM configured for read-old conflict behaviour.

## Interface
- N_RD, 4, number of read requesters (≥1)
- N_WR, 2, number of write requesters (≥1)
- WIDTH, 32, data width
- DEPTH, 512, RAM words; AW = $clog2(DEPTH)
- RAM_LATENCY, 1, read latency of the attached RAM (≥1)

Ports:
- clk  in  1  clock
- s_rst_n  in  1  reset, synchronous, active-low
- rd_req_vld  in  N_RD  read request valid, one bit per requester
- rd_req_add  in  N_RD×AW  read address per requester
- rd_req_rdy  out  N_RD  read request accepted (one-hot or zero)
- wr_req_vld  in  N_WR  write request valid
- wr_req_add  in  N_WR×AW  write address
- wr_req_data  in  N_WR×WIDTH  write data
- wr_req_rdy  out  N_WR  write request accepted (one-hot or zero)
- ram_rd_en  out  1  RAM read enable
- ram_rd_add  out  AW  RAM read address
- ram_rd_data  in  WIDTH  RAM read data, RAM_LATENCY cycles after ram_rd_en
- ram_wr_en  out  1  RAM write enable
- ram_wr_add  out  AW  RAM write address
- ram_wr_data  out  WIDTH  RAM write data
- rsp_vld  out  1  read response valid
- rsp_id  out  $clog2(N_RD) (min 1)  requester index of response
- rsp_data  out  WIDTH  read data (= ram_rd_data)

## Operation
- Valid/ready handshake. A transfer occurs when vld & rdy are both high in the same cycle. Requesters hold vld, address and data stable until accepted.
- Read arbiter: round-robin with pointer rd_ptr (last granted index). The search starts at rd_ptr+1 mod N_RD. The first valid requester gets the grant.
- Write arbiter: identical structure, with its own pointer wr_ptr.
- Both pointers reset to N-1, so requester 0 has top priority after reset.
- A pointer updates to the granted index only when that transfer actually occurs.
- rdy is combinational from vld and the pointers. No dependency on rdy from requesters exists, so there is no loop.
- Collision rule: if the granted read address equals the granted write address in the same cycle, the read is held:
  - all rd_req_rdy are 0 and rd_ptr does not move;
  - the write proceeds;
  - the held read retries the next cycle and then reads the new data.
- Command stage: the accepted read is registered into ram_rd_en/ram_rd_add. The accepted write is registered into ram_wr_en/ram_wr_add/ram_wr_data. ram_*_en is 0 in cycles without acceptance.
- Response tagging:
  - a shift register of depth RAM_LATENCY carries {en, id}, loaded from the command stage;
  - its tail drives rsp_vld/rsp_id;
  - rsp_data is passed straight through from ram_rd_data.
- No response backpressure. Requesters must sink rsp_vld whenever it is asserted.
- Reads and writes are independent otherwise. One read and one write can both be accepted every cycle.

## Timing
- Reset values: rd_req_rdy=0, wr_req_rdy=0, ram_rd_en=0, ram_wr_en=0, rsp_vld=0.
- Also at reset: rd_ptr=N_RD-1, wr_ptr=N_WR-1, and all tag-pipe enables = 0.
- Address, data and id registers are not reset.
- During reset, rdy is forced to 0 regardless of vld.
- Latency: read accepted at cycle T gives ram_rd_en at T+1, and rsp_vld with rsp_id at T+1+RAM_LATENCY.
- Write accepted at T gives ram_wr_en at T+1.
- Read accepted at T+1 after a write accepted at T to the same address returns the new data. This holds because the RAM pipelines read and write identically.
- Throughput: 1 read and 1 write per cycle sustained. With all N requesters valid, each requester gets exactly 1 grant per N cycles.
- Reset mid-operation: in-flight tags are cleared and no rsp_vld follows. The RAM may still produce data, which is ignored.
- N=1: the pointer is degenerate (always 0) and rsp_id is 0.

## Test plan
- Post-reset, all rd_req_vld=4'b1111 held for 8 cycles → grants in order 0,1,2,3,0,1,2,3. rsp_id follows the same order, each RAM_LATENCY+1 cycles after its grant.
- Write 0xDEADBEEF to addr 5 by writer 1 at T; read addr 5 by reader 2 at T+1 → rsp_vld at T+2+RAM_LATENCY, rsp_id=2, rsp_data=0xDEADBEEF.
- Same-cycle collision: reader 0 and writer 0 both on addr 7, write data 0x55 (old content 0x11):
  - write accepted; rd_req_rdy=0;
  - read accepted the next cycle;
  - response returns 0x55, never 0x11.
- Non-colliding simultaneous read addr 3 and write addr 4 → both rdy=1 in the same cycle; ram_rd_en and ram_wr_en both high at the next cycle.
- Reader 1 vld only in alternate cycles while reader 3 vld continuously → reader 1 is granted every cycle it is valid, and reader 3 fills the gaps. No starvation.
- Assert s_rst_n=0 one cycle after 2 reads are accepted (RAM_LATENCY=3) → rsp_vld stays 0 and both rd_ptr and wr_ptr return to their reset values.
- After reset release, a read from requester 0 is granted first.

Source files
------------

// File: rtl/ram_1r1w_arb.sv
// Round-robin front end sharing one 1R1W RAM between N_RD readers and N_WR writers,
// with a registered command stage, in-order response tagging and read-after-write collision hold.
module ram_1r1w_arb #(
  parameter int N_RD        = 4,
  parameter int N_WR        = 2,
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 512,
  parameter int RAM_LATENCY = 1,
  localparam int AW   = $clog2(DEPTH),
  localparam int IDW  = (N_RD > 1) ? $clog2(N_RD) : 1,
  localparam int WIDW = (N_WR > 1) ? $clog2(N_WR) : 1
) (
  input  logic                    clk,
  input  logic                    s_rst_n,
  input  logic [N_RD-1:0]         rd_req_vld,
  input  logic [N_RD*AW-1:0]      rd_req_add,
  output logic [N_RD-1:0]         rd_req_rdy,
  input  logic [N_WR-1:0]         wr_req_vld,
  input  logic [N_WR*AW-1:0]      wr_req_add,
  input  logic [N_WR*WIDTH-1:0]   wr_req_data,
  output logic [N_WR-1:0]         wr_req_rdy,
  output logic                    ram_rd_en,
  output logic [AW-1:0]           ram_rd_add,
  input  logic [WIDTH-1:0]        ram_rd_data,
  output logic                    ram_wr_en,
  output logic [AW-1:0]           ram_wr_add,
  output logic [WIDTH-1:0]        ram_wr_data,
  output logic                    rsp_vld,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_data
);

  logic [IDW-1:0]   rdPtr_q, rdPtr_d, rdGrantIdx;
  logic [WIDW-1:0]  wrPtr_q, wrPtr_d, wrGrantIdx;
  logic             rdGrantVld, wrGrantVld;
  logic [AW-1:0]    rdGrantAdd, wrGrantAdd;
  logic [WIDTH-1:0] wrGrantData;
  logic             collision, rdFire, wrFire;

  logic             ramRdEn_q, ramWrEn_q;
  logic [AW-1:0]    ramRdAdd_q, ramWrAdd_q;
  logic [WIDTH-1:0] ramWrData_q;
  logic [IDW-1:0]   cmdId_q;
  logic [RAM_LATENCY-1:0] tagVld_q;
  logic [IDW-1:0]   tagId_q [RAM_LATENCY];

  // Search starts one past the last granted requester and wraps around.
  always_comb begin
    rdGrantVld = 1'b0;
    rdGrantIdx = '0;
    for (int off = 1; off <= N_RD; off++) begin
      if (!rdGrantVld && rd_req_vld[IDW'((int'(rdPtr_q) + off) % N_RD)]) begin
        rdGrantVld = 1'b1;
        rdGrantIdx = IDW'((int'(rdPtr_q) + off) % N_RD);
      end
    end
    wrGrantVld = 1'b0;
    wrGrantIdx = '0;
    for (int off = 1; off <= N_WR; off++) begin
      if (!wrGrantVld && wr_req_vld[WIDW'((int'(wrPtr_q) + off) % N_WR)]) begin
        wrGrantVld = 1'b1;
        wrGrantIdx = WIDW'((int'(wrPtr_q) + off) % N_WR);
      end
    end
  end

  assign rdGrantAdd  = rd_req_add[rdGrantIdx*AW +: AW];
  assign wrGrantAdd  = wr_req_add[wrGrantIdx*AW +: AW];
  assign wrGrantData = wr_req_data[wrGrantIdx*WIDTH +: WIDTH];

  // A same-address read waits a cycle so it observes the write going out now.
  assign collision = rdGrantVld && wrGrantVld && (rdGrantAdd == wrGrantAdd);
  assign rdFire    = s_rst_n && rdGrantVld && !collision;
  assign wrFire    = s_rst_n && wrGrantVld;
  assign rdPtr_d   = rdFire ? rdGrantIdx : rdPtr_q;
  assign wrPtr_d   = wrFire ? wrGrantIdx : wrPtr_q;

  always_comb begin
    rd_req_rdy = '0;
    wr_req_rdy = '0;
    if (rdFire) rd_req_rdy[rdGrantIdx] = 1'b1;
    if (wrFire) wr_req_rdy[wrGrantIdx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      rdPtr_q   <= IDW'(N_RD - 1);
      wrPtr_q   <= WIDW'(N_WR - 1);
      ramRdEn_q <= 1'b0;
      ramWrEn_q <= 1'b0;
      tagVld_q  <= '0;
    end else begin
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      ramRdEn_q   <= rdFire;
      ramWrEn_q   <= wrFire;
      tagVld_q[0] <= ramRdEn_q;
      for (int i = 1; i < RAM_LATENCY; i++) tagVld_q[i] <= tagVld_q[i-1];
    end
  end

  // Payload registers carry no reset; the enables qualify them.
  always_ff @(posedge clk) begin
    if (rdFire) begin
      ramRdAdd_q <= rdGrantAdd;
      cmdId_q    <= rdGrantIdx;
    end
    if (wrFire) begin
      ramWrAdd_q  <= wrGrantAdd;
      ramWrData_q <= wrGrantData;
    end
    tagId_q[0] <= cmdId_q;
    for (int i = 1; i < RAM_LATENCY; i++) tagId_q[i] <= tagId_q[i-1];
  end

  assign ram_rd_en   = ramRdEn_q;
  assign ram_rd_add  = ramRdAdd_q;
  assign ram_wr_en   = ramWrEn_q;
  assign ram_wr_add  = ramWrAdd_q;
  assign ram_wr_data = ramWrData_q;
  assign rsp_vld     = tagVld_q[RAM_LATENCY-1];
  assign rsp_id      = tagId_q[RAM_LATENCY-1];
  assign rsp_data    = ram_rd_data;

endmodule

// File: tb/tb_ram_1r1w_arb.sv
// Bench for ram_1r1w_arb: directed scenarios plus random traffic, scored against a
// word-array memory model and round-robin grant model through an expected-response queue.
module tb_ram_1r1w_arb;

  localparam int N_RD  = 4;
  localparam int N_WR  = 2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;
  localparam int AW    = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  s_rst_n;
  logic [N_RD-1:0]       rdVld;
  logic [N_RD*AW-1:0]    rdAdd;
  logic [N_RD-1:0]       rd_req_rdy;
  logic [N_WR-1:0]       wrVld;
  logic [N_WR*AW-1:0]    wrAdd;
  logic [N_WR*WIDTH-1:0] wrData;
  logic [N_WR-1:0]       wr_req_rdy;
  logic                  ram_rd_en, ram_wr_en, rsp_vld;
  logic [AW-1:0]         ram_rd_add, ram_wr_add;
  logic [WIDTH-1:0]      ramRdData, ram_wr_data, rsp_data;
  logic [IDW-1:0]        rsp_id;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  ram_1r1w_arb #(.N_RD(N_RD), .N_WR(N_WR), .WIDTH(WIDTH), .DEPTH(DEPTH), .RAM_LATENCY(LAT)) dut (
    .clk(clk), .s_rst_n(s_rst_n),
    .rd_req_vld(rdVld), .rd_req_add(rdAdd), .rd_req_rdy(rd_req_rdy),
    .wr_req_vld(wrVld), .wr_req_add(wrAdd), .wr_req_data(wrData), .wr_req_rdy(wr_req_rdy),
    .ram_rd_en(ram_rd_en), .ram_rd_add(ram_rd_add), .ram_rd_data(ramRdData),
    .ram_wr_en(ram_wr_en), .ram_wr_add(ram_wr_add), .ram_wr_data(ram_wr_data),
    .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] initWord(input int i);
    return 32'hA500_0000 | WIDTH'(i);
  endfunction

  // Attached RAM: read-old on a same-cycle conflict, LAT-cycle read pipeline.
  logic [WIDTH-1:0] ramMem [DEPTH];
  logic [WIDTH-1:0] ramPipe [LAT];
  logic             ramInitDone = 1'b0;
  always @(posedge clk) begin
    if (!ramInitDone) begin
      for (int i = 0; i < DEPTH; i++) ramMem[i] <= initWord(i);
      ramInitDone <= 1'b1;
    end else if (ram_wr_en) begin
      ramMem[ram_wr_add] <= ram_wr_data;
    end
    for (int i = LAT - 1; i > 0; i--) ramPipe[i] <= ramPipe[i-1];
    ramPipe[0] <= ram_rd_en ? ramMem[ram_rd_add] : 'x;
  end
  assign ramRdData = ramPipe[LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reportFail(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: logical memory contents, grant pointers and expected responses.
  typedef struct { int due; int id; logic [WIDTH-1:0] data; } rsp_t;
  rsp_t expQ [$];
  logic [WIDTH-1:0] refMem [DEPTH];
  int mRdPtr, mWrPtr;
  logic [N_RD-1:0] rdAccM = '0;
  logic [N_WR-1:0] wrAccM = '0;

  function automatic int rrPick(input logic [7:0] vld, input int n, input int ptr);
    for (int k = 1; k <= n; k++) begin
      int idx;
      idx = (ptr + k) % n;
      if (vld[idx]) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int rg, wg;
    logic [N_RD-1:0] expRd;
    logic [N_WR-1:0] expWr;
    if (!s_rst_n) begin
      mRdPtr = N_RD - 1;
      mWrPtr = N_WR - 1;
      expQ.delete();
      rdAccM = '0;
      wrAccM = '0;
      checkOutput("rdyInReset", {rd_req_rdy, wr_req_rdy}, 64'd0);
    end else begin
      wg = rrPick(8'(wrVld), N_WR, mWrPtr);
      rg = rrPick(8'(rdVld), N_RD, mRdPtr);
      if (rg >= 0 && wg >= 0 && rdAdd[rg*AW +: AW] == wrAdd[wg*AW +: AW]) rg = -1;
      expRd = '0;
      expWr = '0;
      if (rg >= 0) expRd[rg] = 1'b1;
      if (wg >= 0) expWr[wg] = 1'b1;
      checkOutput("rdRdy", 64'(rd_req_rdy), 64'(expRd));
      checkOutput("wrRdy", 64'(wr_req_rdy), 64'(expWr));
      if (wg >= 0) begin
        refMem[wrAdd[wg*AW +: AW]] = wrData[wg*WIDTH +: WIDTH];
        mWrPtr = wg;
      end
      if (rg >= 0) begin
        expQ.push_back('{cyc + 1 + LAT, rg, refMem[rdAdd[rg*AW +: AW]]});
        mRdPtr = rg;
      end
      rdAccM = expRd;
      wrAccM = expWr;
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge clk) begin
    rsp_t e;
    if (s_rst_n) begin
      if (expQ.size() > 0 && expQ[0].due < cyc) begin
        reportFail("rspMissing");
        void'(expQ.pop_front());
      end
      if (rsp_vld) begin
        if (expQ.size() == 0) begin
          reportFail("rspUnexpected");
        end else begin
          e = expQ.pop_front();
          checkOutput("rspCycle", 64'(cyc), 64'(e.due));
          checkOutput("rspId", 64'(rsp_id), 64'(e.id));
          checkOutput("rspData", 64'(rsp_data), 64'(e.data));
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sampleNow();
    @(negedge clk);
    #1;
  endtask

  task automatic doWrite(input int w, input int a, input logic [WIDTH-1:0] d);
    bit done = 0;
    wrVld[w] = 1'b1;
    wrAdd[w*AW +: AW] = AW'(a);
    wrData[w*WIDTH +: WIDTH] = d;
    for (int k = 0; k < 50 && !done; k++) begin
      sampleNow();
      done = wrAccM[w];
    end
    if (!done) reportFail("writeTimeout");
    nextCycle();
    wrVld[w] = 1'b0;
  endtask

  task automatic doRead(input int r, input int a);
    bit done = 0;
    rdVld[r] = 1'b1;
    rdAdd[r*AW +: AW] = AW'(a);
    for (int k = 0; k < 50 && !done; k++) begin
      sampleNow();
      done = rdAccM[r];
    end
    if (!done) reportFail("readTimeout");
    nextCycle();
    rdVld[r] = 1'b0;
  endtask

  // Random requesters: hold each request until accepted, then maybe issue a new one.
  task automatic applyStimulus();
    for (int r = 0; r < N_RD; r++) begin
      if (rdAccM[r]) rdVld[r] = 1'b0;
      if (!rdVld[r] && $urandom_range(0, 1) == 1) begin
        rdVld[r] = 1'b1;
        rdAdd[r*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
      end
    end
    for (int w = 0; w < N_WR; w++) begin
      if (wrAccM[w]) wrVld[w] = 1'b0;
      if (!wrVld[w] && $urandom_range(0, 1) == 1) begin
        wrVld[w] = 1'b1;
        wrAdd[w*AW +: AW] = AW'($urandom_range(0, DEPTH - 1));
        wrData[w*WIDTH +: WIDTH] = $urandom;
      end
    end
  endtask

  function automatic int oneHotIdx(input logic [N_RD-1:0] v);
    for (int i = 0; i < N_RD; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
    s_rst_n = 1'b0;
    rdVld = '1;
    wrVld = '0;
    wrData = '0;
    for (int r = 0; r < N_RD; r++) rdAdd[r*AW +: AW] = AW'(8 + r);
    for (int w = 0; w < N_WR; w++) wrAdd[w*AW +: AW] = AW'(12 + w);

    // Reset values with all readers requesting
    repeat (3) nextCycle();
    sampleNow();
    checkOutput("resetRdEn", 64'(ram_rd_en), 64'd0);
    checkOutput("resetWrEn", 64'(ram_wr_en), 64'd0);
    checkOutput("resetRspVld", 64'(rsp_vld), 64'd0);
    nextCycle();
    s_rst_n = 1'b1;

    // All readers valid: strict rotation starting at 0
    for (int i = 0; i < 8; i++) begin
      sampleNow();
      checkOutput("rotationGrant", 64'(oneHotIdx(rd_req_rdy)), 64'(i % N_RD));
      nextCycle();
    end
    rdVld = '0;
    repeat (LAT + 3) nextCycle();

    // Write then read the same address on the next cycle
    doWrite(1, 5, 32'hDEADBEEF);
    doRead(2, 5);
    repeat (LAT + 3) nextCycle();

    // Same-cycle collision: the read must wait and see the new data
    doWrite(0, 7, 32'h11);
    repeat (2) nextCycle();
    rdVld[0] = 1'b1;
    rdAdd[0*AW +: AW] = AW'(7);
    wrVld[0] = 1'b1;
    wrAdd[0*AW +: AW] = AW'(7);
    wrData[0*WIDTH +: WIDTH] = 32'h55;
    sampleNow();
    checkOutput("collisionRdRdy", 64'(rd_req_rdy), 64'd0);
    checkOutput("collisionWrRdy", 64'(wr_req_rdy), 64'b01);
    nextCycle();
    wrVld[0] = 1'b0;
    sampleNow();
    checkOutput("collisionRetry", 64'(rd_req_rdy), 64'b0001);
    nextCycle();
    rdVld[0] = 1'b0;
    repeat (LAT + 3) nextCycle();

    // Independent read and write in the same cycle
    rdVld[0] = 1'b1;
    rdAdd[0*AW +: AW] = AW'(3);
    wrVld[0] = 1'b1;
    wrAdd[0*AW +: AW] = AW'(4);
    wrData[0*WIDTH +: WIDTH] = 32'h0BAD_F00D;
    sampleNow();
    checkOutput("parallelRdRdy", 64'(rd_req_rdy), 64'b0001);
    checkOutput("parallelWrRdy", 64'(wr_req_rdy), 64'b01);
    nextCycle();
    rdVld = '0;
    wrVld = '0;
    sampleNow();
    checkOutput("parallelRdEn", 64'(ram_rd_en), 64'd1);
    checkOutput("parallelWrEn", 64'(ram_wr_en), 64'd1);
    checkOutput("parallelRdAdd", 64'(ram_rd_add), 64'd3);
    checkOutput("parallelWrAdd", 64'(ram_wr_add), 64'd4);
    nextCycle();
    repeat (LAT + 3) nextCycle();

    // Reader 1 on alternate cycles, reader 3 always: 1 wins when present, 3 fills gaps
    rdAdd[1*AW +: AW] = AW'(9);
    rdAdd[3*AW +: AW] = AW'(10);
    for (int i = 0; i < 8; i++) begin
      rdVld[3] = 1'b1;
      rdVld[1] = (i % 2 == 0);
      sampleNow();
      checkOutput("fairnessGrant", 64'(rd_req_rdy), (i % 2 == 0) ? 64'b0010 : 64'b1000);
      nextCycle();
    end
    rdVld = '0;
    repeat (LAT + 3) nextCycle();

    // Reset with two reads in flight: no responses, pointers back to reset values
    rdVld[0] = 1'b1;
    rdAdd[0*AW +: AW] = AW'(1);
    sampleNow();
    checkOutput("inflightRead0", 64'(rd_req_rdy), 64'b0001);
    nextCycle();
    rdVld[0] = 1'b0;
    rdVld[1] = 1'b1;
    rdAdd[1*AW +: AW] = AW'(2);
    sampleNow();
    checkOutput("inflightRead1", 64'(rd_req_rdy), 64'b0010);
    nextCycle();
    rdVld = '0;
    s_rst_n = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sampleNow();
      checkOutput("noRspAfterReset", 64'(rsp_vld), 64'd0);
      nextCycle();
      if (k == 2) s_rst_n = 1'b1;
    end
    rdVld = '1;
    wrVld = '1;
    for (int r = 0; r < N_RD; r++) rdAdd[r*AW +: AW] = AW'(8 + r);
    for (int w = 0; w < N_WR; w++) wrAdd[w*AW +: AW] = AW'(12 + w);
    sampleNow();
    checkOutput("postResetRdFirst", 64'(rd_req_rdy), 64'b0001);
    checkOutput("postResetWrFirst", 64'(wr_req_rdy), 64'b01);
    nextCycle();
    rdVld = '0;
    wrVld = '0;
    repeat (LAT + 3) nextCycle();

    // Random traffic over a small address space so collisions are frequent
    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      nextCycle();
    end
    rdVld = '0;
    wrVld = '0;
    repeat (LAT + 6) nextCycle();
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
